reg_file: RTL and testbench

- MIPS32 general-purpose register file: 32 registers x 32 bits.
- Two combinational read ports (rs/rt) and one synchronous write port (rd/rt writeback).
- Sits between the decode stage (read addresses) and the writeback stage (write address/data) of the datapath.
- Register 0 is hardwired to zero.

---
 rtl/reg_file_if.sv | 24 ++
 rtl/reg_file.sv | 56 +++++
 tb/tb_reg_file.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Register-file bus: two combinational read ports and one synchronous write port.
// The master (decode/writeback side) drives addresses and write data; the slave returns read data.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we3;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  modport master (
    output we3, ra1, ra2, wa3, wd3,
    input  rd1, rd2
  );

  modport slave (
    input  we3, ra1, ra2, wa3, wd3,
    output rd1, rd2
  );
endinterface

// File: rtl/reg_file.sv
// MIPS32 general-purpose register file: 2**ADDR_W x DATA_W, register 0 hardwired to zero.
// Optional macro WRITE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_file_if.slave   bus
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [0:NREGS-1];
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // Writes to register 0 are dropped here; its slot is never loaded outside reset.
  assign w_wr_en = rst_n & bus.we3 & (bus.wa3 != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[bus.wa3] <= bus.wd3;
    end
  end

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (bus.ra1 != '0) begin
      w_rd1 = r_regs[bus.ra1];
`ifdef WRITE_BYPASS_EN
      if (w_wr_en && (bus.wa3 == bus.ra1)) begin
        w_rd1 = bus.wd3;
      end
`endif
    end
    if (bus.ra2 != '0) begin
      w_rd2 = r_regs[bus.ra2];
`ifdef WRITE_BYPASS_EN
      if (w_wr_en && (bus.wa3 == bus.ra2)) begin
        w_rd2 = bus.wd3;
      end
`endif
    end
  end

  assign bus.rd1 = w_rd1;
  assign bus.rd2 = w_rd2;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, write/read, zero register, sweep, read-during-write.
module tb_reg_file;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_if ();

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus_if.we3 = we;
    bus_if.wa3 = wa;
    bus_if.wd3 = wd;
    bus_if.ra1 = a1;
    bus_if.ra2 = a2;
    #1;
  endtask

  logic [31:0] exp1;
  logic [31:0] exp2;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    check("r0_before_reset_rd1", bus_if.rd1, 32'h0);
    check("r0_before_reset_rd2", bus_if.rd2, 32'h0);

    // Write r5, then reset with a competing write: reset must win.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    tick();
    check("pre_reset_r5", bus_if.rd1, 32'hDEADBEEF);
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check("reset_r5_rd1", bus_if.rd1, 32'h0);
    check("reset_r5_rd2", bus_if.rd2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check("reset_all_rd1", bus_if.rd1, 32'h0);
      check("reset_all_rd2", bus_if.rd2, 32'h0);
    end

    // Basic write/read.
    drive(1'b1, 5'd1, 32'h00000001, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd0);
    check("basic_rd1", bus_if.rd1, 32'h00000001);
    check("basic_rd2", bus_if.rd2, 32'h00000000);

    // Write disabled leaves r1 intact.
    drive(1'b0, 5'd1, 32'h0, 5'd1, 5'd1);
    tick();
    check("we_off_rd1", bus_if.rd1, 32'h00000001);
    check("we_off_rd2", bus_if.rd2, 32'h00000001);

    // Writes to r0 are discarded.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("zero_rd1", bus_if.rd1, 32'h0);
    check("zero_rd2", bus_if.rd2, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd0);
    check("zero_write_keeps_r1", bus_if.rd1, 32'h00000001);

    // Full sweep: reg[i] = i * 0x01010101.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      exp1 = 32'(i) * 32'h01010101;
      exp2 = 32'(31 - i) * 32'h01010101;
      check("sweep_rd1", bus_if.rd1, exp1);
      check("sweep_rd2", bus_if.rd2, exp2);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    check("sweep_r31_both", bus_if.rd2, 32'h1F1F1F1F);

    // Read-during-write on r7: old 0x11, new 0x22.
    drive(1'b1, 5'd7, 32'h00000011, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd7, 32'h00000022, 5'd7, 5'd7);
`ifdef WRITE_BYPASS_EN
    check("rdw_before_rd1", bus_if.rd1, 32'h00000022);
    check("rdw_before_rd2", bus_if.rd2, 32'h00000022);
`else
    check("rdw_before_rd1", bus_if.rd1, 32'h00000011);
    check("rdw_before_rd2", bus_if.rd2, 32'h00000011);
`endif
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    check("rdw_after_rd1", bus_if.rd1, 32'h00000022);
    check("rdw_after_rd2", bus_if.rd2, 32'h00000022);

    // Pending write to r0 never shows on a port addressing r0.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7);
    check("rdw_r0_rd1", bus_if.rd1, 32'h0);
    check("rdw_r0_other_rd2", bus_if.rd2, 32'h00000022);

    // Reset asserted with a pending write: no forwarding, then all cleared.
    rst_n = 1'b0;
    drive(1'b1, 5'd7, 32'h00000033, 5'd7, 5'd9);
    check("rst_pending_rd1", bus_if.rd1, 32'h00000022);
    check("rst_pending_rd2", bus_if.rd2, 32'h09090909);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd9);
    check("midreset_r7", bus_if.rd1, 32'h0);
    check("midreset_r9", bus_if.rd2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
